// File: rtl/data_mem_arb_pkg.sv
// Shared types for the data memory arbiter.
// Arbiter FSM states, requester ids and hold limit default.
package data_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOCK_CORE = 2'd1,
        LOCK_DBG  = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } req_id_t;

    localparam int MAX_HOLD_DEFAULT = 8;

endpackage

// File: rtl/rr_select2.sv
// Two-way winner selection for the data memory arbiter.
// A lock owner wins while valid; otherwise round robin.
import data_mem_arb_pkg::*;

module rr_select2 (
    input  logic       core_valid,
    input  logic       dbg_valid,
    input  arb_state_t state,
    input  req_id_t    last_grant,
    output logic       grant,
    output req_id_t    winner
);

    // Pick the winner from lock ownership, then fairness
    always_comb begin
        grant  = core_valid | dbg_valid;
        winner = REQ_CORE;
        if (state == LOCK_CORE && core_valid) begin
            winner = REQ_CORE;
        end else if (state == LOCK_DBG && dbg_valid) begin
            winner = REQ_DBG;
        end else if (core_valid && dbg_valid) begin
            winner = (last_grant == REQ_CORE) ? REQ_DBG
                                              : REQ_CORE;
        end else if (dbg_valid) begin
            winner = REQ_DBG;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Core/debug arbiter in front of the single-port data memory.
// Supports locked bursts bounded by MAX_HOLD beats.
import data_mem_arb_pkg::*;

module data_mem_arbiter #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DATA_DEPTH = 128,
    parameter  int MAX_HOLD   = MAX_HOLD_DEFAULT,
    localparam int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  core_req_valid,
    output logic                  core_req_ready,
    input  logic                  core_req_wr,
    input  logic                  core_req_lock,
    input  logic [ADDR_WIDTH-1:0] core_req_addr,
    input  logic [DATA_WIDTH-1:0] core_req_wdata,
    output logic                  core_rsp_valid,
    output logic [DATA_WIDTH-1:0] core_rsp_rdata,
    input  logic                  dbg_req_valid,
    output logic                  dbg_req_ready,
    input  logic                  dbg_req_wr,
    input  logic                  dbg_req_lock,
    input  logic [ADDR_WIDTH-1:0] dbg_req_addr,
    input  logic [DATA_WIDTH-1:0] dbg_req_wdata,
    output logic                  dbg_rsp_valid,
    output logic [DATA_WIDTH-1:0] dbg_rsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_wr,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  grant_id
);

    localparam int CW = $clog2(MAX_HOLD + 1);

    arb_state_t      state_q, state_d;
    logic [CW-1:0]   hold_q, hold_d;
    logic [CW-1:0]   hold_base, hold_inc;
    req_id_t         last_q;
    req_id_t         winner;
    logic            grant;
    logic            win_wr, win_lock;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic            core_rsp_q, dbg_rsp_q;

    rr_select2 u_sel (
        .core_valid (core_req_valid & rst_n),
        .dbg_valid  (dbg_req_valid & rst_n),
        .state      (state_q),
        .last_grant (last_q),
        .grant      (grant),
        .winner     (winner)
    );

    // Route the winning request to the memory port
    always_comb begin
        win_wr    = core_req_wr;
        win_lock  = core_req_lock;
        win_addr  = core_req_addr;
        win_wdata = core_req_wdata;
        if (winner == REQ_DBG) begin
            win_wr    = dbg_req_wr;
            win_lock  = dbg_req_lock;
            win_addr  = dbg_req_addr;
            win_wdata = dbg_req_wdata;
        end
        core_req_ready = grant & (winner == REQ_CORE);
        dbg_req_ready  = grant & (winner == REQ_DBG);
        mem_wr         = grant & win_wr;
        mem_address    = grant ? win_addr : '0;
        mem_write_data = grant ? win_wdata : '0;
    end

    // Lock state and hold count for the next cycle
    always_comb begin
        state_d   = IDLE;
        hold_d    = '0;
        hold_base = '0;
        if ((winner == REQ_CORE && state_q == LOCK_CORE) ||
            (winner == REQ_DBG  && state_q == LOCK_DBG)) begin
            hold_base = hold_q;
        end
        hold_inc = hold_base + 1'b1;
        if (grant && win_lock && hold_inc < CW'(MAX_HOLD)) begin
            state_d = (winner == REQ_CORE) ? LOCK_CORE
                                           : LOCK_DBG;
            hold_d  = hold_inc;
        end
    end

    // FSM, hold counter and last grant registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            last_q  <= REQ_DBG;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            if (grant) begin
                last_q <= winner;
            end
        end
    end

    // Capture read data and flag a response per accepted beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            core_rsp_q     <= 1'b0;
            dbg_rsp_q      <= 1'b0;
            core_rsp_rdata <= '0;
            dbg_rsp_rdata  <= '0;
        end else begin
            core_rsp_q <= core_req_ready;
            dbg_rsp_q  <= dbg_req_ready;
            if (core_req_ready) begin
                core_rsp_rdata <= core_req_wr ? '0 : mem_read_data;
            end
            if (dbg_req_ready) begin
                dbg_rsp_rdata <= dbg_req_wr ? '0 : mem_read_data;
            end
        end
    end

    // A reset arriving during the pulse cycle suppresses it
    assign core_rsp_valid = core_rsp_q & rst_n;
    assign dbg_rsp_valid  = dbg_rsp_q & rst_n;
    assign grant_id       = last_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter with a memory model,
// a behavioural arbitration model and a response scoreboard.
import data_mem_arb_pkg::*;

module tb_data_mem_arbiter;

    localparam int DW    = 32;
    localparam int DEPTH = 128;
    localparam int AW    = 7;
    localparam int MH    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          core_req_valid, core_req_ready, core_req_wr;
    logic          core_req_lock;
    logic [AW-1:0] core_req_addr;
    logic [DW-1:0] core_req_wdata;
    logic          core_rsp_valid;
    logic [DW-1:0] core_rsp_rdata;
    logic          dbg_req_valid, dbg_req_ready, dbg_req_wr;
    logic          dbg_req_lock;
    logic [AW-1:0] dbg_req_addr;
    logic [DW-1:0] dbg_req_wdata;
    logic          dbg_rsp_valid;
    logic [DW-1:0] dbg_rsp_rdata;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic          mem_wr;
    logic [DW-1:0] mem_read_data;
    logic          grant_id;

    data_mem_arbiter #(
        .DATA_WIDTH (DW),
        .DATA_DEPTH (DEPTH),
        .MAX_HOLD   (MH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .core_req_valid (core_req_valid),
        .core_req_ready (core_req_ready),
        .core_req_wr    (core_req_wr),
        .core_req_lock  (core_req_lock),
        .core_req_addr  (core_req_addr),
        .core_req_wdata (core_req_wdata),
        .core_rsp_valid (core_rsp_valid),
        .core_rsp_rdata (core_rsp_rdata),
        .dbg_req_valid  (dbg_req_valid),
        .dbg_req_ready  (dbg_req_ready),
        .dbg_req_wr     (dbg_req_wr),
        .dbg_req_lock   (dbg_req_lock),
        .dbg_req_addr   (dbg_req_addr),
        .dbg_req_wdata  (dbg_req_wdata),
        .dbg_rsp_valid  (dbg_rsp_valid),
        .dbg_rsp_rdata  (dbg_rsp_rdata),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_wr         (mem_wr),
        .mem_read_data  (mem_read_data),
        .grant_id       (grant_id)
    );

    always #5 clk = ~clk;

    // Behavioural data memory: combinational read, write at edge
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_address] <= mem_write_data;
    end
    assign mem_read_data = mem[mem_address];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t q_core[$];
    exp_t q_dbg[$];

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    int owner = -1;
    int burst = 0;
    int last  = 1;
    bit pending [2];

    task automatic chk(string name, logic [31:0] act,
                       logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    // Scoreboard monitor: responses due this cycle must appear
    always @(negedge clk) begin
        exp_t e;
        if (q_core.size() > 0 && q_core[0].due == cyc) begin
            e = q_core.pop_front();
            chk("core_rsp_valid", core_rsp_valid, 1);
            chk("core_rsp_rdata", core_rsp_rdata, e.data);
        end else begin
            chk("core_rsp_idle", core_rsp_valid, 0);
        end
        if (q_dbg.size() > 0 && q_dbg[0].due == cyc) begin
            e = q_dbg.pop_front();
            chk("dbg_rsp_valid", dbg_rsp_valid, 1);
            chk("dbg_rsp_rdata", dbg_rsp_rdata, e.data);
        end else begin
            chk("dbg_rsp_idle", dbg_rsp_valid, 0);
        end
    end

    function automatic int predict();
        if (owner == 0 && core_req_valid) return 0;
        if (owner == 1 && dbg_req_valid) return 1;
        if (core_req_valid && dbg_req_valid) return 1 - last;
        if (core_req_valid) return 0;
        if (dbg_req_valid) return 1;
        return -1;
    endfunction

    task automatic set_req(int id, bit v, bit w, bit l,
                           int a, logic [DW-1:0] d);
        if (id == 0) begin
            core_req_valid = v;
            core_req_wr    = w;
            core_req_lock  = l;
            core_req_addr  = a[AW-1:0];
            core_req_wdata = d;
        end else begin
            dbg_req_valid = v;
            dbg_req_wr    = w;
            dbg_req_lock  = l;
            dbg_req_addr  = a[AW-1:0];
            dbg_req_wdata = d;
        end
        pending[id] = v;
    endtask

    // One clock of arbitration checked against the model
    task automatic step();
        int            win;
        int            a;
        logic [DW-1:0] d;
        bit            w, l;
        exp_t          e;
        @(negedge clk);
        win = predict();
        chk("core_req_ready", core_req_ready, win == 0);
        chk("dbg_req_ready", dbg_req_ready, win == 1);
        if (win < 0) begin
            chk("mem_wr_idle", mem_wr, 0);
            chk("mem_address_idle", mem_address, 0);
            owner = -1;
            burst = 0;
        end else begin
            a = (win == 1) ? int'(dbg_req_addr)
                           : int'(core_req_addr);
            d = (win == 1) ? dbg_req_wdata : core_req_wdata;
            w = (win == 1) ? dbg_req_wr : core_req_wr;
            l = (win == 1) ? dbg_req_lock : core_req_lock;
            chk("mem_wr", mem_wr, w);
            chk("mem_address", mem_address, a);
            if (w) chk("mem_write_data", mem_write_data, d);
            e.due = cyc + 1;
            if (w) begin
                ref_mem[a] = d;
                e.data = '0;
            end else begin
                e.data = ref_mem[a];
            end
            if (win == 0) q_core.push_back(e);
            else q_dbg.push_back(e);
            burst = (owner == win) ? burst + 1 : 1;
            if (l && burst < MH) begin
                owner = win;
            end else begin
                owner = -1;
                burst = 0;
            end
            last = win;
            pending[win] = 0;
        end
        @(posedge clk);
        #1;
        chk("grant_id", grant_id, last);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q_core.delete();
        q_dbg.delete();
        owner = -1;
        burst = 0;
        last  = 1;
        set_req(0, 1, 1, 1, 3, '1);
        set_req(1, 1, 0, 1, 4, '0);
        @(negedge clk);
        chk("rst_core_ready", core_req_ready, 0);
        chk("rst_dbg_ready", dbg_req_ready, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_core_rsp_valid", core_rsp_valid, 0);
        chk("rst_dbg_rsp_valid", dbg_rsp_valid, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rst_core_rdata", core_rsp_rdata, 0);
        chk("rst_dbg_rdata", dbg_rsp_rdata, 0);
        chk("rst_grant_id", grant_id, 1);
        chk("rst_state", dut.state_q, IDLE);
        chk("rst_hold", dut.hold_q, 0);
        set_req(0, 0, 0, 0, 0, '0);
        set_req(1, 0, 0, 0, 0, '0);
        rst_n = 1'b1;
    endtask

    initial begin
        int k;
        int nmis;
        do_reset();

        // Fill every word through the core port
        for (int i = 0; i < DEPTH; i++) begin
            set_req(0, 1, 1, 0, i, $urandom);
            step();
        end
        set_req(0, 0, 0, 0, 0, '0);

        // Core write then core read of the same word
        set_req(0, 1, 1, 0, 5, 32'hDEADBEEF);
        step();
        set_req(0, 1, 0, 0, 5, '0);
        step();
        set_req(0, 0, 0, 0, 0, '0);
        chk("wr_rd_valid", core_rsp_valid, 1);
        chk("wr_rd_rdata", core_rsp_rdata, 32'hDEADBEEF);

        // Core write followed at once by a debug read
        set_req(0, 1, 1, 0, 7, 32'h12345678);
        step();
        set_req(0, 0, 0, 0, 0, '0);
        set_req(1, 1, 0, 0, 7, '0);
        step();
        set_req(1, 0, 0, 0, 0, '0);
        chk("fwd_valid", dbg_rsp_valid, 1);
        chk("fwd_rdata", dbg_rsp_rdata, 32'h12345678);

        // Tie alternation straight after reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1, 0, 0, 1, '0);
            set_req(1, 1, 0, 0, 2, '0);
            step();
            chk("tie_grant", grant_id, i % 2);
        end
        set_req(0, 0, 0, 0, 0, '0);
        set_req(1, 0, 0, 0, 0, '0);

        // Debug locked burst of three beats against core
        set_req(0, 1, 0, 0, 0, '0);
        step();
        set_req(0, 1, 0, 0, 20, '0);
        for (int i = 0; i < 3; i++) begin
            set_req(1, 1, 0, i < 2, 10 + i, '0);
            step();
            chk("lock_grant", grant_id, 1);
        end
        set_req(1, 0, 0, 0, 0, '0);
        step();
        chk("lock_after", grant_id, 0);
        set_req(0, 0, 0, 0, 0, '0);

        // Debug holds lock for 12 beats; release after MH
        set_req(0, 1, 0, 0, 0, '0);
        step();
        k = 0;
        for (int b = 1; b <= 12; b++) begin
            if (!pending[0]) set_req(0, 1, 0, 0, 30, '0);
            if (!pending[1]) begin
                set_req(1, 1, 0, 1, 40 + k, '0);
                k++;
            end
            step();
            chk("force_grant", grant_id, (b == 9) ? 0 : 1);
            if (b == 7) begin
                chk("force_hold7", dut.hold_q, 7);
                chk("force_state7", dut.state_q, LOCK_DBG);
            end
            if (b == 9) begin
                chk("force_hold9", dut.hold_q, 0);
                chk("force_state9", dut.state_q, IDLE);
            end
        end
        set_req(0, 0, 0, 0, 0, '0);
        set_req(1, 0, 0, 0, 0, '0);
        step();

        // Reset in the cycle after an accepted debug read
        set_req(1, 1, 0, 1, 3, '0);
        step();
        do_reset();
        chk("midrst_dbg_valid", dbg_rsp_valid, 0);

        // Randomized traffic with frequent locks
        for (int n = 0; n < 800; n++) begin
            for (int id = 0; id < 2; id++) begin
                if (!pending[id]) begin
                    if ($urandom_range(3) != 0)
                        set_req(id, 1, $urandom_range(1) == 1,
                                $urandom_range(3) != 0,
                                $urandom_range(DEPTH - 1),
                                $urandom);
                    else
                        set_req(id, 0, 0, 0, 0, '0);
                end
            end
            step();
        end
        set_req(0, 0, 0, 0, 0, '0);
        set_req(1, 0, 0, 0, 0, '0);
        step();
        step();
        chk("core_q_empty", q_core.size(), 0);
        chk("dbg_q_empty", q_dbg.size(), 0);

        nmis = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i] !== ref_mem[i]) nmis++;
        end
        chk("mem_contents", nmis, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
